irq_ctrl: RTL
=============

# irq_ctrl

External-interrupt front end for the pipelined CPU, sitting directly upstream of the CP0 unit. It synchronises up to `N_IRQ` asynchronous interrupt lines, rising-edge detects them into a maskable pending register, and selects the highest-priority source. It then issues a single-cycle request that drives CP0's external interrupt input and holds off further requests until CP0 executes ERET. Cause and mask state are exposed for MFC0-style reads.

## Interface
- `N_IRQ`, default 8: number of interrupt lines, range 1..16.
- `clk`  in  1: main clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `irq_lines`  in  N_IRQ: raw external interrupt lines, asynchronous to `clk`.
- `mask_we`  in  1: write enable for the mask register.
- `mask_wdata`  in  N_IRQ: new mask value; 1 = enabled.
- `pend_clr`  in  N_IRQ: software clear of pending bits; one-cycle strobe per bit.
- `eret`  in  1: ERET executing in CP0 this cycle; same cycle CP0 restores the PC.
- `ir_req`  out  1: one-cycle pulse, wired to CP0's external interrupt input.
- `irq_id`  out  4: index of the source currently in service.
- `irq_busy`  out  1: a request has been issued and ERET has not yet been seen.
- `irq_pending`  out  N_IRQ: pending register.
- `irq_mask`  out  N_IRQ: mask register.

## Operation
- **Synchroniser:** two-flop chain `s1 → s2` per line, plus `prev <= s2`.
- **Edge detect:** `rise = s2 & ~prev`.
- **Pending register:** `pending <= (pending & ~clr_vec) | rise`.
  - `clr_vec = pend_clr`, plus the one-hot bit of the source being dispatched when entering REQ.
  - Set wins over clear for the same bit in the same cycle.
- **Mask register:** loads `mask_wdata` when `mask_we`. Masking does not clear pending bits; it only hides them from selection.
- **Selection:** `cand = pending & mask`. The lowest index wins. `sel` is its index, and is meaningful only when `cand != 0`.
- **FSM** (states IDLE, REQ, BUSY):
  - IDLE → REQ when `cand != 0`. Latch `irq_id <= sel` and clear that pending bit on the same edge.
  - REQ → BUSY unconditionally after one cycle. `ir_req = (state == REQ)`.
  - BUSY → IDLE when `eret`.
  - `eret` in IDLE or REQ is ignored. It does not shorten REQ and does not clear pending.
- `irq_busy = (state != IDLE)`. `irq_id` holds its value through BUSY and into IDLE until the next dispatch.
- Edges arriving during REQ or BUSY accumulate in `pending`. Multiple edges on one line while it is still pending collapse into one event.
- **Mask change in REQ or BUSY:** has no effect on the in-flight request. The dispatched source is already committed.
- **Asynchronous reset:**
  - `s1`, `s2`, `prev`, `pending`, `mask`, `irq_id` all go to 0; state goes to IDLE.
  - Therefore `ir_req=0`, `irq_busy=0`, `irq_pending=0`, `irq_mask=0`, `irq_id=0`.
  - Reset mid-operation discards all pending and in-flight requests immediately; no pulse completes.
- A line held high at reset release produces one event once `s2` rises and `prev` is still 0.

## Timing
- **Line-to-request latency:** line high before edge E1 → `s1` at E1 → `s2` at E2 → `pending` set at E3 → state REQ at E4. `ir_req` is high from E4 to E5, exactly one cycle.
- **Back-to-back:** after `eret` at edge Ek (BUSY → IDLE), a still-pending enabled source enters REQ at Ek+1. The minimum gap between `ir_req` pulses is therefore 2 cycles after ERET.
- **Mask write:** takes effect for selection in the cycle after the write edge.
- **Pending clear:** `pend_clr` takes effect on the same edge.
- **Outputs:** `ir_req` and `irq_busy` are decoded from registered state and are glitch-free. `irq_pending` and `irq_mask` are direct register outputs.
- **CP0 contract:** `ir_req` is a pulse; CP0 latches it into its wait flag and arbitrates with its own interrupt enable.

## Test plan
- **Single interrupt:** mask=0xFF; raise line 3 for 1 cycle → `ir_req` pulses exactly once, 4 edges later, with `irq_id=3`, `irq_pending=0x00` and `irq_busy=1`. Pulse `eret` → `irq_busy=0` next edge.
- **Priority:** mask=0xFF; raise lines 5 and 2 in the same cycle → first dispatch has `irq_id=2` and pending shows 0x20. `eret` → second dispatch with `irq_id=5` one edge after IDLE; total of 2 `ir_req` pulses.
- **Masking:** mask=0xFB; raise line 2 → pending=0x04 and no `ir_req` for 20 cycles. Write mask=0xFF → `ir_req` within 2 edges, `irq_id=2`.
- **Collapse during BUSY:** raise line 1 → dispatched, BUSY. Toggle line 1 three times during BUSY → pending=0x02. After `eret`, exactly one further `ir_req`.
- **Stray eret:** pulse `eret` in IDLE and again in the REQ cycle → FSM still reaches BUSY. `pending` is unchanged except for the dispatched bit.
- **Reset:** assert `rst` asynchronously mid-BUSY with pending=0x30 → all outputs 0 immediately, without waiting for a clock edge. After release, no `ir_req` appears while lines stay low.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: external-interrupt front end ahead of CP0.
// Synchronises the raw lines, edge-detects them into a maskable pending
// register, picks the lowest-index enabled source and hands it to CP0 as a
// single-cycle request. No further request is issued until CP0 executes ERET.
module irq_ctrl #(
  parameter int N_IRQ = 8  // 1..16, bounded by the 4-bit irq_id
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_lines,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic [N_IRQ-1:0] pend_clr,
  input  logic             eret,
  output logic             ir_req,
  output logic [3:0]       irq_id,
  output logic             irq_busy,
  output logic [N_IRQ-1:0] irq_pending,
  output logic [N_IRQ-1:0] irq_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N_IRQ-1:0] s1, s2, prev;
  logic [N_IRQ-1:0] pending, mask;
  logic [N_IRQ-1:0] rise, cand, clr_vec, sel_onehot;
  logic [3:0]       sel;
  logic             dispatch;

  // Two-flop synchroniser per line, plus the delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= irq_lines;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
  assign cand = pending & mask;

  // Lowest-index enabled pending source; scanning downwards lets the
  // lowest index overwrite any higher one.
  // NOTE: every output of a combinational block is given a default first
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel        = '0;
    sel_onehot = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel           = 4'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign dispatch = (state == IDLE) && (cand != '0);
  assign clr_vec  = pend_clr | (dispatch ? sel_onehot : '0);

  // Pending register: software/dispatch clear, with a new edge winning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | rise;
    end
  end

  // Mask register: hides pending bits from selection, never clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  // Captures the dispatched source; held until the next dispatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_id <= '0;
    end else if (dispatch) begin
      irq_id <= sel;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: ERET is only meaningful once the request is in BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cand != '0) state_nxt = REQ;
      REQ:     state_nxt = BUSY;
      BUSY:    if (eret) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ir_req      = (state == REQ);
  assign irq_busy    = (state != IDLE);
  assign irq_pending = pending;
  assign irq_mask    = mask;

endmodule
